// File: rtl/stump_mem_arbiter.sv
// Shares the Stump memory bus between the CPU port and a debug/DMA port.
// Define STUMP_ARB_RR_EN for round-robin grants; default is fixed CPU priority.
module stump_mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_wen,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        err
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dbg_win_q, dbg_win_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic        err_q, err_d;
    logic        grant_dbg;
    logic        finish;

`ifdef STUMP_ARB_RR_EN
    logic last_dbg_q, last_dbg_d;

    // On contention the port that did not win last time goes first.
    assign grant_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

    always_comb begin
        last_dbg_d = last_dbg_q;
        if (state_q == IDLE && (cpu_req || dbg_req)) begin
            last_dbg_d = grant_dbg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end
`else
    assign grant_dbg = ~cpu_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dbg_win_d   = dbg_win_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        ren_d       = 1'b0;
        wen_d       = 1'b0;
        err_d       = 1'b0;
        finish      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    dbg_win_d = grant_dbg;
                    wr_d      = grant_dbg ? dbg_wen : cpu_wen;
                    addr_d    = grant_dbg ? dbg_addr : cpu_addr;
                    wdata_d   = grant_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d     = '0;
                    ren_d     = ~wr_d;
                    wen_d     = wr_d;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_rdy) begin
                    if (!wr_q) begin
                        if (dbg_win_q) begin
                            dbg_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // Timed out: read data registers keep their old value.
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    ren_d = ~wr_q;
                    wen_d = wr_q;
                end
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cpu_ack_d = finish & ~dbg_win_q;
        dbg_ack_d = finish & dbg_win_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dbg_win_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dbg_win_q   <= dbg_win_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            err_q       <= err_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_ren   = ren_q;
    assign mem_wen   = wen_q;
    assign err       = err_q;

endmodule
